// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the ifu/lsu memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_IFU, BUSY_LSU} state_t;
  typedef enum logic {REQ_IFU, REQ_LSU} req_id_t;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;
endpackage

// File: rtl/mem_arb_slot.sv
// mem_arb_slot: one-deep pending request slot; a set while already pending is dropped
module mem_arb_slot
  import mem_arb_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic set,
  input  logic clr,
  input  req_t din,
  output logic pending,
  output req_t dout
);
  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= 1'b0;
      dout    <= '0;
    end else if (clr) begin
      pending <= 1'b0;
    end else if (set && !pending) begin
      pending <= 1'b1;
      dout    <= din;
    end
  end
endmodule

// File: rtl/mem_arb.sv
// mem_arb: round-robin 2:1 arbiter sharing one memory port between ifu and lsu, with a response watchdog
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_ifu_reqValid,
  input  logic [31:0] io_ifu_addr,
  output logic        io_ifu_respValid,
  output logic [31:0] io_ifu_rdata,
  output logic        io_ifu_err,
  input  logic        io_lsu_reqValid,
  input  logic [31:0] io_lsu_addr,
  input  logic [1:0]  io_lsu_size,
  input  logic        io_lsu_wen,
  input  logic [31:0] io_lsu_wdata,
  input  logic [3:0]  io_lsu_wmask,
  output logic        io_lsu_respValid,
  output logic [31:0] io_lsu_rdata,
  output logic        io_lsu_err,
  output logic        io_mem_reqValid,
  output logic [31:0] io_mem_addr,
  output logic [1:0]  io_mem_size,
  output logic        io_mem_wen,
  output logic [31:0] io_mem_wdata,
  output logic [3:0]  io_mem_wmask,
  input  logic        io_mem_respValid,
  input  logic [31:0] io_mem_rdata
);
  state_t           state;
  req_id_t          last_grant;
  logic [CNT_W-1:0] cnt;
  logic             ifu_pend, lsu_pend, gnt_ifu, gnt_lsu, timeout, done;
  req_t             ifu_q, lsu_q, mem_q;

  mem_arb_slot u_ifu_slot (
    .clock   (clock),
    .reset   (reset),
    .set     (io_ifu_reqValid && state != BUSY_IFU),
    .clr     (gnt_ifu),
    .din     ('{addr: io_ifu_addr, size: SIZE_WORD, wen: 1'b0, wdata: 32'h0, wmask: 4'h0}),
    .pending (ifu_pend),
    .dout    (ifu_q)
  );

  mem_arb_slot u_lsu_slot (
    .clock   (clock),
    .reset   (reset),
    .set     (io_lsu_reqValid && state != BUSY_LSU),
    .clr     (gnt_lsu),
    .din     ('{addr: io_lsu_addr, size: io_lsu_size, wen: io_lsu_wen, wdata: io_lsu_wdata, wmask: io_lsu_wmask}),
    .pending (lsu_pend),
    .dout    (lsu_q)
  );

  // grants look only at captured requests, so same-cycle reqValid waits a cycle
  assign gnt_ifu = state == IDLE && ifu_pend && (!lsu_pend || last_grant == REQ_LSU);
  assign gnt_lsu = state == IDLE && lsu_pend && !gnt_ifu;
  assign timeout = TIMEOUT != 0 && cnt == CNT_W'(TIMEOUT - 1);
  assign done    = !reset && state != IDLE && (io_mem_respValid || timeout);

  assign io_ifu_respValid = done && state == BUSY_IFU;
  assign io_ifu_rdata     = io_ifu_respValid && io_mem_respValid ? io_mem_rdata : 32'h0;
  assign io_ifu_err       = io_ifu_respValid && !io_mem_respValid;
  assign io_lsu_respValid = done && state == BUSY_LSU;
  assign io_lsu_rdata     = io_lsu_respValid && io_mem_respValid ? io_mem_rdata : 32'h0;
  assign io_lsu_err       = io_lsu_respValid && !io_mem_respValid;

  assign io_mem_addr  = mem_q.addr;
  assign io_mem_size  = mem_q.size;
  assign io_mem_wen   = mem_q.wen;
  assign io_mem_wdata = mem_q.wdata;
  assign io_mem_wmask = mem_q.wmask;

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      last_grant      <= REQ_LSU;
      cnt             <= '0;
      mem_q           <= '0;
      io_mem_reqValid <= 1'b0;
    end else begin
      io_mem_reqValid <= gnt_ifu || gnt_lsu;
      if (gnt_ifu || gnt_lsu) begin
        state      <= gnt_ifu ? BUSY_IFU : BUSY_LSU;
        last_grant <= gnt_ifu ? REQ_IFU : REQ_LSU;
        mem_q      <= gnt_ifu ? ifu_q : lsu_q;
        cnt        <= '0;
      end else if (done) begin
        state <= IDLE;
        mem_q <= '0;
        cnt   <= '0;
      end else if (state != IDLE) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed scenarios with a queue scoreboard checked by a negedge monitor
module tb_mem_arb;
  import mem_arb_pkg::*;
  logic        clock = 1'b0, reset = 1'b1;
  logic        io_ifu_reqValid = 1'b0, io_lsu_reqValid = 1'b0, io_lsu_wen = 1'b0, io_mem_respValid = 1'b0;
  logic [31:0] io_ifu_addr = '0, io_lsu_addr = '0, io_lsu_wdata = '0, io_mem_rdata = '0;
  logic [1:0]  io_lsu_size = '0;
  logic [3:0]  io_lsu_wmask = '0;
  logic        io_ifu_respValid, io_ifu_err, io_lsu_respValid, io_lsu_err, io_mem_reqValid, io_mem_wen;
  logic [31:0] io_ifu_rdata, io_lsu_rdata, io_mem_addr, io_mem_wdata;
  logic [1:0]  io_mem_size;
  logic [3:0]  io_mem_wmask;
  int          total = 0, bad = 0;
  req_t        mq[$];
  logic [32:0] iq[$], lq[$];
  req_t        held, cur;
  logic        busy = 1'b0;

  mem_arb #(.TIMEOUT(8), .CNT_W(4)) dut (
    .clock(clock), .reset(reset),
    .io_ifu_reqValid(io_ifu_reqValid), .io_ifu_addr(io_ifu_addr),
    .io_ifu_respValid(io_ifu_respValid), .io_ifu_rdata(io_ifu_rdata), .io_ifu_err(io_ifu_err),
    .io_lsu_reqValid(io_lsu_reqValid), .io_lsu_addr(io_lsu_addr), .io_lsu_size(io_lsu_size),
    .io_lsu_wen(io_lsu_wen), .io_lsu_wdata(io_lsu_wdata), .io_lsu_wmask(io_lsu_wmask),
    .io_lsu_respValid(io_lsu_respValid), .io_lsu_rdata(io_lsu_rdata), .io_lsu_err(io_lsu_err),
    .io_mem_reqValid(io_mem_reqValid), .io_mem_addr(io_mem_addr), .io_mem_size(io_mem_size),
    .io_mem_wen(io_mem_wen), .io_mem_wdata(io_mem_wdata), .io_mem_wmask(io_mem_wmask),
    .io_mem_respValid(io_mem_respValid), .io_mem_rdata(io_mem_rdata)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s got=pulse want=none", name);
  endtask

  always @(negedge clock) begin
    cur = '{io_mem_addr, io_mem_size, io_mem_wen, io_mem_wdata, io_mem_wmask};
    if (io_mem_reqValid) begin
      if (mq.size() == 0) flag("mem_unexpected");
      else check("mem_req", cur, mq.pop_front());
      held = cur;
      busy = 1'b1;
    end else if (busy) check("mem_stable", cur, held);
    else check("mem_idle_zero", cur, '0);
    if (io_ifu_respValid) begin
      if (iq.size() == 0) flag("ifu_unexpected");
      else check("ifu_resp", {io_ifu_err, io_ifu_rdata}, iq.pop_front());
    end else check("ifu_quiet", {io_ifu_err, io_ifu_rdata}, '0);
    if (io_lsu_respValid) begin
      if (lq.size() == 0) flag("lsu_unexpected");
      else check("lsu_resp", {io_lsu_err, io_lsu_rdata}, lq.pop_front());
    end else check("lsu_quiet", {io_lsu_err, io_lsu_rdata}, '0);
    if (io_ifu_respValid || io_lsu_respValid || reset) busy = 1'b0;
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_ifu(input logic [31:0] a);
    io_ifu_reqValid = 1'b1;
    io_ifu_addr = a;
  endtask

  task automatic drive_lsu(input logic [31:0] a, input logic [1:0] s, input logic w,
                           input logic [31:0] d, input logic [3:0] m);
    io_lsu_reqValid = 1'b1;
    io_lsu_addr = a;
    io_lsu_size = s;
    io_lsu_wen = w;
    io_lsu_wdata = d;
    io_lsu_wmask = m;
  endtask

  task automatic release_reqs();
    cyc();
    io_ifu_reqValid = 1'b0;
    io_lsu_reqValid = 1'b0;
    io_ifu_addr = '0;
    io_lsu_addr = '0;
    io_lsu_wdata = '0;
  endtask

  task automatic wait_mem_req(input string name);
    int n = 0;
    while (!io_mem_reqValid && n < 20) begin
      cyc();
      n++;
    end
    check(name, io_mem_reqValid, 1'b1);
  endtask

  task automatic respond(input int d, input logic [31:0] data);
    repeat (d) cyc();
    io_mem_respValid = 1'b1;
    io_mem_rdata = data;
    cyc();
    io_mem_respValid = 1'b0;
    io_mem_rdata = '0;
  endtask

  task automatic ifu_txn(input logic [31:0] a, input logic [31:0] data);
    mq.push_back(req_t'{a, SIZE_WORD, 1'b0, 32'h0, 4'h0});
    iq.push_back({1'b0, data});
    drive_ifu(a);
    release_reqs();
    wait_mem_req("ifu_txn_grant");
    respond(2, data);
    cyc();
  endtask

  task automatic check_all_zero(input string name);
    check(name, |{io_ifu_respValid, io_ifu_rdata, io_ifu_err, io_lsu_respValid, io_lsu_rdata, io_lsu_err,
                  io_mem_reqValid, io_mem_addr, io_mem_size, io_mem_wen, io_mem_wdata, io_mem_wmask}, 1'b0);
  endtask

  initial begin
    repeat (2) cyc();
    reset = 1'b0;
    check_all_zero("reset_outputs");
    // ifu only: grant lands two cycles after the request
    mq.push_back(req_t'{32'h8000_0000, 2'b10, 1'b0, 32'h0, 4'h0});
    iq.push_back({1'b0, 32'h13});
    drive_ifu(32'h8000_0000);
    release_reqs();
    check("ifu_lat_n1", io_mem_reqValid, 1'b0);
    cyc();
    check("ifu_lat_n2", io_mem_reqValid, 1'b1);
    respond(3, 32'h13);
    cyc();
    // lsu store
    mq.push_back(req_t'{32'h100, 2'b10, 1'b1, 32'h0000_AB00, 4'b0010});
    lq.push_back({1'b0, 32'h0});
    drive_lsu(32'h100, 2'b10, 1'b1, 32'h0000_AB00, 4'b0010);
    release_reqs();
    wait_mem_req("lsu_grant");
    respond(4, 32'h0);
    cyc();
    // tie after reset: ifu first, lsu right after the ifu response
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    mq.push_back(req_t'{32'h1000, 2'b10, 1'b0, 32'h0, 4'h0});
    mq.push_back(req_t'{32'h2000, 2'b00, 1'b0, 32'h0, 4'h0});
    iq.push_back({1'b0, 32'h11});
    lq.push_back({1'b0, 32'h22});
    drive_ifu(32'h1000);
    drive_lsu(32'h2000, 2'b00, 1'b0, 32'h0, 4'h0);
    release_reqs();
    wait_mem_req("tie1_first");
    respond(1, 32'h11);
    check("tie1_gap", io_mem_reqValid, 1'b0);
    cyc();
    check("tie1_second", io_mem_reqValid, 1'b1);
    respond(1, 32'h22);
    cyc();
    // after an ifu grant, the next tie goes to lsu first
    ifu_txn(32'h3000, 32'h33);
    mq.push_back(req_t'{32'h4000, 2'b01, 1'b1, 32'h55, 4'b0011});
    mq.push_back(req_t'{32'h5000, 2'b10, 1'b0, 32'h0, 4'h0});
    lq.push_back({1'b0, 32'h44});
    iq.push_back({1'b0, 32'h50});
    drive_ifu(32'h5000);
    drive_lsu(32'h4000, 2'b01, 1'b1, 32'h55, 4'b0011);
    release_reqs();
    wait_mem_req("tie2_first");
    respond(1, 32'h44);
    wait_mem_req("tie2_second");
    respond(1, 32'h50);
    cyc();
    // watchdog: error on the 8th busy cycle, late response ignored
    mq.push_back(req_t'{32'h200, 2'b01, 1'b0, 32'h77, 4'h0});
    lq.push_back({1'b1, 32'h0});
    drive_lsu(32'h200, 2'b01, 1'b0, 32'h77, 4'h0);
    release_reqs();
    wait_mem_req("to_grant");
    repeat (6) cyc();
    check("to_busy7", io_lsu_respValid, 1'b0);
    cyc();
    check("to_busy8", io_lsu_respValid, 1'b1);
    respond(2, 32'hDEAD);
    repeat (2) cyc();
    // reset mid busy with lsu pending: everything abandoned
    mq.push_back(req_t'{32'h6000, 2'b10, 1'b0, 32'h0, 4'h0});
    drive_ifu(32'h6000);
    release_reqs();
    wait_mem_req("rst_mid_grant");
    drive_lsu(32'h7000, 2'b10, 1'b0, 32'h0, 4'h0);
    release_reqs();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_all_zero("rst_mid_outputs");
    repeat (5) cyc();
    ifu_txn(32'h8000, 32'h88);
    // overrun: second ifu pulse while in flight is dropped
    mq.push_back(req_t'{32'h9000, 2'b10, 1'b0, 32'h0, 4'h0});
    iq.push_back({1'b0, 32'h99});
    drive_ifu(32'h9000);
    release_reqs();
    wait_mem_req("ovr_grant");
    cyc();
    drive_ifu(32'hA000);
    release_reqs();
    respond(2, 32'h99);
    repeat (6) cyc();
    check("mq_drained", mq.size(), 0);
    check("iq_drained", iq.size(), 0);
    check("lq_drained", lq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
